// File: rtl/mem_byte_sequencer_if.sv
// mem_byte_sequencer_if: control-unit request/response and RAM beat bus of the byte sequencer.
interface mem_byte_sequencer_if #(parameter int ADDR_W = 8);
  logic              req;
  logic              rw;
  logic [1:0]        dt;
  logic              sign;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic [31:0]       rdata;
  logic [1:0]        err;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;
  modport slave (
    input  req, rw, dt, sign, addr, wdata, mem_rdata, mem_ack,
    output busy, done, rdata, err, mem_en, mem_rw, mem_addr, mem_wdata
  );
  modport master (
    output req, rw, dt, sign, addr, wdata, mem_rdata, mem_ack,
    input  busy, done, rdata, err, mem_en, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer: splits byte/halfword/word accesses into big-endian RAM byte beats.
module mem_byte_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  clr,
  mem_byte_sequencer_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT, GAP, DONE} state_t;
  state_t            r_st;
  logic              r_rw, r_sign, r_busy, r_done, r_en;
  logic [1:0]        r_dt, r_idx, r_err;
  logic [ADDR_W-1:0] r_base, r_maddr;
  logic [31:0]       r_wdata, r_rdata;
  logic [23:0]       r_acc;
  logic [7:0]        r_tmr, r_mwdata;
  logic [31:0]       w_acc, w_fmt;
  logic [1:0]        w_last, w_sel;
  logic              w_bad;
  logic [7:0]        w_byte;
  always_comb begin
    w_acc  = {r_acc, bus.mem_rdata};
    w_fmt  = r_dt == 2'b00 ? {{24{r_sign & w_acc[7]}}, w_acc[7:0]} :
             r_dt == 2'b01 ? {{16{r_sign & w_acc[15]}}, w_acc[15:0]} : w_acc;
    w_last = r_dt == 2'b00 ? 2'd0 : r_dt == 2'b01 ? 2'd1 : 2'd3;
    w_bad  = r_dt == 2'b11 || (r_dt[0] && r_base[0]) || (r_dt[1] && r_base[1:0] != 2'b00);
    w_sel  = w_last - r_idx;
    w_byte = 8'(r_wdata >> {w_sel, 3'b000});
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      r_st    <= IDLE;
      r_rw    <= 1'b0;
      r_sign  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_en    <= 1'b0;
      r_dt    <= '0;
      r_idx   <= '0;
      r_err   <= '0;
      r_base  <= '0;
      r_maddr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_acc   <= '0;
      r_tmr   <= '0;
      r_mwdata <= '0;
    end else
      case (r_st)
        IDLE: if (bus.req) begin
          r_rw    <= bus.rw;
          r_dt    <= bus.dt;
          r_sign  <= bus.sign;
          r_base  <= bus.addr;
          r_wdata <= bus.wdata;
          r_idx   <= '0;
          r_tmr   <= '0;
          r_acc   <= '0;
          r_busy  <= 1'b1;
          r_st    <= CHECK;
        end
        // CHECK and GAP both launch the beat at r_idx; w_bad can only hold in CHECK
        CHECK, GAP: if (w_bad) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_err  <= 2'b01;
          r_st   <= DONE;
        end else begin
          r_en     <= 1'b1;
          r_maddr  <= r_base + ADDR_W'(r_idx);
          r_mwdata <= w_byte;
          r_tmr    <= '0;
          r_st     <= ISSUE;
        end
        ISSUE, WAIT: if (bus.mem_ack) begin
          r_en  <= 1'b0;
          r_acc <= w_acc[23:0];
          if (r_idx == w_last) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_err  <= 2'b00;
            if (r_rw) r_rdata <= w_fmt;
            r_st <= DONE;
          end else begin
            r_idx <= r_idx + 2'd1;
            r_st  <= GAP;
          end
        end else if (r_tmr == 8'(TIMEOUT - 1)) begin
          r_en   <= 1'b0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_err  <= 2'b10;
          r_st   <= DONE;
        end else begin
          r_tmr <= r_tmr + 8'd1;
          r_st  <= WAIT;
        end
        DONE: begin
          r_done <= 1'b0;
          r_st   <= IDLE;
        end
        default: r_st <= IDLE;
      endcase
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.rdata     = r_rdata;
  assign bus.err       = r_err;
  assign bus.mem_en    = r_en;
  assign bus.mem_rw    = r_rw;
  assign bus.mem_addr  = r_maddr;
  assign bus.mem_wdata = r_mwdata;
endmodule

// File: tb/tb_mem_byte_sequencer.sv
// tb_mem_byte_sequencer: directed checks of beat sequencing, formatting, errors and reset.
module tb_mem_byte_sequencer;
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;
  mem_byte_sequencer_if #(.ADDR_W(8)) bus ();
  mem_byte_sequencer #(.ADDR_W(8), .TIMEOUT(16)) dut (.clk(clk), .clr(clr), .bus(bus));
  logic [7:0] rom [256];
  int ack_dly = 0;
  int wcnt = 0;
  int en_total = 0;
  int beat_n = 0;
  int done_total = 0;
  int unstable = 0;
  logic [7:0] log_a [64];
  logic [7:0] log_d [64];
  logic prev_en = 1'b0, prev_ack = 1'b0;
  logic [7:0] prev_a = '0, prev_d = '0;
  assign bus.mem_ack   = bus.mem_en && (wcnt >= ack_dly);
  assign bus.mem_rdata = rom[bus.mem_addr];
  // RAM-side monitor: counts enable cycles, logs accepted beats, flags unstable waits
  always @(posedge clk) begin
    if (bus.mem_en) en_total <= en_total + 1;
    if (bus.done) done_total <= done_total + 1;
    if (bus.mem_en && bus.mem_ack) begin
      log_a[beat_n] <= bus.mem_addr;
      log_d[beat_n] <= bus.mem_wdata;
      beat_n <= beat_n + 1;
    end
    if (bus.mem_en && prev_en && !prev_ack && (bus.mem_addr != prev_a || bus.mem_wdata != prev_d))
      unstable <= unstable + 1;
    wcnt     <= (bus.mem_en && !bus.mem_ack) ? wcnt + 1 : 0;
    prev_en  <= bus.mem_en;
    prev_ack <= bus.mem_ack;
    prev_a   <= bus.mem_addr;
    prev_d   <= bus.mem_wdata;
  end
  int checks = 0;
  int errors = 0;
  int lat, e0, b0, d0;
  logic bsy1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic access(input logic rw_i, input logic [1:0] dt_i, input logic sg,
                        input logic [7:0] a, input logic [31:0] wd, input int poke);
    @(negedge clk);
    bus.req = 1'b1;
    bus.rw = rw_i;
    bus.dt = dt_i;
    bus.sign = sg;
    bus.addr = a;
    bus.wdata = wd;
    lat = -1;
    e0 = en_total;
    b0 = beat_n;
    d0 = done_total;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      bus.req = (k == poke);
      if (k == 1) bsy1 = bus.busy;
      if (bus.done) begin
        lat = k + 1;
        break;
      end
    end
    bus.req = 1'b0;
  endtask
  initial begin
    bus.req = 1'b0;
    bus.rw = 1'b0;
    bus.dt = 2'b00;
    bus.sign = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h10] = 8'h12;
    rom[8'h11] = 8'h34;
    rom[8'h12] = 8'h56;
    rom[8'h13] = 8'h78;
    rom[8'h05] = 8'h80;
    rom[8'h40] = 8'hA5;
    rom[8'h41] = 8'h3C;
    #1 clr = 1'b1;
    #1;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'h0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    access(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, 0);
    chk("word_rd_lat", 32'(lat), 32'd10);
    chk("word_rd_data", bus.rdata, 32'h12345678);
    chk("word_rd_err", 32'(bus.err), 32'h0);
    chk("word_rd_en_cycles", 32'(en_total - e0), 32'd4);
    chk("word_rd_addrs", {log_a[b0], log_a[b0+1], log_a[b0+2], log_a[b0+3]}, 32'h10111213);
    chk("word_rd_busy_after_req", 32'(bsy1), 32'h1);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'h0);
    chk("busy_after_done", 32'(bus.busy), 32'h0);
    access(1'b1, 2'b00, 1'b1, 8'h05, 32'h0, 0);
    chk("sbyte_lat", 32'(lat), 32'd4);
    chk("sbyte_data", bus.rdata, 32'hFFFFFF80);
    access(1'b1, 2'b00, 1'b0, 8'h05, 32'h0, 0);
    chk("ubyte_data", bus.rdata, 32'h00000080);
    access(1'b1, 2'b01, 1'b1, 8'h40, 32'h0, 0);
    chk("shalf_lat", 32'(lat), 32'd6);
    chk("shalf_data", bus.rdata, 32'hFFFFA53C);
    ack_dly = 3;
    access(1'b0, 2'b01, 1'b0, 8'h20, 32'h0000BEEF, 0);
    chk("hwr_lat", 32'(lat), 32'd12);
    chk("hwr_addrs", {16'h0, log_a[b0], log_a[b0+1]}, 32'h00002021);
    chk("hwr_bytes", {16'h0, log_d[b0], log_d[b0+1]}, 32'h0000BEEF);
    chk("hwr_en_cycles", 32'(en_total - e0), 32'd8);
    chk("hwr_stable", 32'(unstable), 32'd0);
    chk("hwr_rdata_kept", bus.rdata, 32'hFFFFA53C);
    chk("hwr_err", 32'(bus.err), 32'h0);
    ack_dly = 0;
    access(1'b0, 2'b00, 1'b0, 8'h07, 32'h123456AB, 0);
    chk("bwr_lat", 32'(lat), 32'd4);
    chk("bwr_beat", {log_a[b0], log_d[b0]}, 32'h000007AB);
    access(1'b1, 2'b10, 1'b0, 8'h22, 32'h0, 0);
    chk("misal_word_lat", 32'(lat), 32'd3);
    chk("misal_word_err", 32'(bus.err), 32'h1);
    chk("misal_word_no_en", 32'(en_total - e0), 32'd0);
    access(1'b1, 2'b11, 1'b0, 8'h00, 32'h0, 0);
    chk("dt11_lat", 32'(lat), 32'd3);
    chk("dt11_err", 32'(bus.err), 32'h1);
    chk("dt11_no_en", 32'(en_total - e0), 32'd0);
    access(1'b0, 2'b01, 1'b0, 8'h21, 32'h0, 0);
    chk("misal_half_err", 32'(bus.err), 32'h1);
    chk("misal_rdata_kept", bus.rdata, 32'hFFFFA53C);
    access(1'b1, 2'b00, 1'b0, 8'h05, 32'h0, 0);
    chk("err_cleared", 32'(bus.err), 32'h0);
    chk("ubyte2_data", bus.rdata, 32'h00000080);
    ack_dly = 1000;
    access(1'b1, 2'b10, 1'b0, 8'h10, 32'h0, 5);
    chk("tmo_lat", 32'(lat), 32'd19);
    chk("tmo_err", 32'(bus.err), 32'h2);
    chk("tmo_en_cycles", 32'(en_total - e0), 32'd16);
    chk("tmo_rdata_kept", bus.rdata, 32'h00000080);
    repeat (6) @(negedge clk);
    chk("busy_req_ignored", 32'(bus.busy), 32'h0);
    chk("busy_req_no_en", 32'(en_total - e0), 32'd16);
    chk("busy_req_one_done", 32'(done_total - d0), 32'd1);
    ack_dly = 5;
    @(negedge clk);
    bus.req = 1'b1;
    bus.rw = 1'b1;
    bus.dt = 2'b10;
    bus.sign = 1'b0;
    bus.addr = 8'h10;
    d0 = done_total;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bus.req = 1'b0;
    end
    chk("rst_mid_pre_en", 32'(bus.mem_en), 32'h1);
    chk("rst_mid_pre_addr", 32'(bus.mem_addr), 32'h11);
    #2 clr = 1'b1;
    #1;
    chk("rst_mid_en", 32'(bus.mem_en), 32'h0);
    chk("rst_mid_busy", 32'(bus.busy), 32'h0);
    chk("rst_mid_rdata", bus.rdata, 32'h0);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_done", 32'(done_total - d0), 32'd0);
    ack_dly = 0;
    access(1'b1, 2'b00, 1'b0, 8'h05, 32'h0, 0);
    chk("post_rst_lat", 32'(lat), 32'd4);
    chk("post_rst_data", bus.rdata, 32'h00000080);
    chk("post_rst_err", 32'(bus.err), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
